// File: rtl/spram_loader_pkg.sv
// spram_loader_pkg: shared state encodings and FIFO sizing for the download loader
package spram_loader_pkg;
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_DRAIN  = 3'd2;
    localparam logic [2:0] S_VERIFY = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;
    localparam int FIFO_DEPTH = 2;
endpackage

// File: rtl/loader_skid_fifo.sv
// loader_skid_fifo: 2-entry FIFO decoupling the download stream from RAM port contention
module loader_skid_fifo
    import spram_loader_pkg::*;
#(
    parameter int width = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [width-1:0] din,
    output logic [width-1:0] dout,
    output logic             full,
    output logic             empty
);
    logic [width-1:0] mem [FIFO_DEPTH];
    logic rd_ptr, wr_ptr;
    logic [1:0] count;
    logic do_push, do_pop;

    assign full    = count == 2'(FIFO_DEPTH);
    assign empty   = count == 2'd0;
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) wr_ptr <= ~wr_ptr;
            if (do_pop) rd_ptr <= ~rd_ptr;
            count <= count + 2'(do_push) - 2'(do_pop);
        end
    end
endmodule

// File: rtl/spram_loader.sv
// spram_loader: streams a download into a CPU-shared single-port RAM, then reads it back to verify
module spram_loader
    import spram_loader_pkg::*;
#(
    parameter int address_width = 8,
    parameter int data_width    = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     dl_active,
    input  logic                     dl_valid,
    input  logic [data_width-1:0]    dl_data,
    output logic                     dl_ready,
    input  logic                     cpu_req,
    input  logic [address_width-1:0] cpu_address,
    input  logic [data_width-1:0]    cpu_data,
    input  logic                     cpu_wren,
    output logic [address_width-1:0] ram_address,
    output logic [data_width-1:0]    ram_data,
    output logic                     ram_wren,
    input  logic [data_width-1:0]    ram_q,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    output logic [address_width:0]   byte_count,
    output logic [data_width-1:0]    checksum
);
    localparam logic [address_width:0] capacity = {1'b1, {address_width{1'b0}}};

    logic [2:0] state;
    logic dl_prev, overflow, pending;
    logic [address_width:0] accepted, read_ptr;
    logic [data_width-1:0] verify_sum, sum_next, fifo_q;
    logic fifo_full, fifo_empty, push, pop, issue, rise, fall, load_start;

    assign rise       = dl_active & ~dl_prev;
    assign fall       = ~dl_active & dl_prev;
    assign load_start = rise & (state == S_IDLE || state == S_DONE);
    assign dl_ready   = state == S_LOAD && !fifo_full;
    // Past capacity, bytes are still acknowledged but never enter the FIFO.
    assign push       = dl_valid && dl_ready && accepted != capacity;
    assign pop        = (state == S_LOAD || state == S_DRAIN) && !cpu_req && !fifo_empty;
    assign issue      = state == S_VERIFY && !cpu_req && read_ptr != byte_count;
    assign sum_next   = verify_sum + ram_q;
    assign busy       = state == S_LOAD || state == S_DRAIN || state == S_VERIFY;
    assign done       = state == S_DONE;

    always_comb begin
        ram_address = cpu_req ? cpu_address
                    : state == S_VERIFY ? read_ptr[address_width-1:0] : byte_count[address_width-1:0];
        ram_data    = cpu_req ? cpu_data : fifo_q;
        ram_wren    = cpu_req ? cpu_wren : pop;
    end

    loader_skid_fifo #(.width(data_width)) fifo (
        .clock (clock),
        .reset (reset),
        .clear (load_start),
        .push  (push),
        .pop   (pop),
        .din   (dl_data),
        .dout  (fifo_q),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            dl_prev    <= 1'b0;
            overflow   <= 1'b0;
            accepted   <= '0;
            byte_count <= '0;
            checksum   <= '0;
            error      <= 1'b0;
            read_ptr   <= '0;
            pending    <= 1'b0;
            verify_sum <= '0;
        end else begin
            dl_prev <= dl_active;
            if (load_start) begin
                state      <= S_LOAD;
                overflow   <= 1'b0;
                accepted   <= '0;
                byte_count <= '0;
                checksum   <= '0;
                error      <= 1'b0;
            end else begin
                if (push) accepted <= accepted + 1'b1;
                if (dl_valid && dl_ready && accepted == capacity) overflow <= 1'b1;
                if (pop) begin
                    byte_count <= byte_count + 1'b1;
                    checksum   <= checksum + fifo_q;
                end
                if (state == S_LOAD && fall) state <= S_DRAIN;
                if (state == S_DRAIN && fifo_empty) begin
                    if (byte_count == '0) begin
                        state <= S_DONE;
                        error <= overflow;
                    end else begin
                        state      <= S_VERIFY;
                        read_ptr   <= '0;
                        pending    <= 1'b0;
                        verify_sum <= '0;
                    end
                end
                // ram_q belongs to the read issued last cycle; CPU-held cycles issue nothing.
                if (state == S_VERIFY) begin
                    pending <= issue;
                    if (issue) read_ptr <= read_ptr + 1'b1;
                    if (pending) verify_sum <= sum_next;
                    if (pending && read_ptr == byte_count) begin
                        state <= S_DONE;
                        error <= overflow | (sum_next != checksum);
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_spram_loader.sv
// tb_spram_loader: directed bench with a write scoreboard, two loader sizes and behavioural RAMs
module tb_spram_loader;
    import spram_loader_pkg::*;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset, dl_active, dl_valid, cpu_req, cpu_wren;
    logic [7:0] dl_data, cpu_address, cpu_data;

    logic dl_ready1, ram_wren1, busy1, done1, error1;
    logic [7:0] ram_address1, ram_data1, ram_q1, checksum1;
    logic [8:0] byte_count1;

    logic dl_ready2, ram_wren2, busy2, done2, error2;
    logic [1:0] ram_address2;
    logic [7:0] ram_data2, ram_q2, checksum2;
    logic [2:0] byte_count2;

    logic [7:0] mem1 [256];
    logic [7:0] mem2 [4];

    spram_loader #(.address_width(8), .data_width(8)) dut1 (
        .clock(clock), .reset(reset), .dl_active(dl_active), .dl_valid(dl_valid), .dl_data(dl_data),
        .dl_ready(dl_ready1), .cpu_req(cpu_req), .cpu_address(cpu_address), .cpu_data(cpu_data),
        .cpu_wren(cpu_wren), .ram_address(ram_address1), .ram_data(ram_data1), .ram_wren(ram_wren1),
        .ram_q(ram_q1), .busy(busy1), .done(done1), .error(error1), .byte_count(byte_count1),
        .checksum(checksum1)
    );

    spram_loader #(.address_width(2), .data_width(8)) dut2 (
        .clock(clock), .reset(reset), .dl_active(dl_active), .dl_valid(dl_valid), .dl_data(dl_data),
        .dl_ready(dl_ready2), .cpu_req(cpu_req), .cpu_address(cpu_address[1:0]), .cpu_data(cpu_data),
        .cpu_wren(cpu_wren), .ram_address(ram_address2), .ram_data(ram_data2), .ram_wren(ram_wren2),
        .ram_q(ram_q2), .busy(busy2), .done(done2), .error(error2), .byte_count(byte_count2),
        .checksum(checksum2)
    );

    always @(posedge clock) begin
        if (ram_wren1) mem1[ram_address1] <= ram_data1;
        ram_q1 <= mem1[ram_address1];
        if (ram_wren2) mem2[ram_address2] <= ram_data2;
        ram_q2 <= mem2[ram_address2];
    end

    int checks = 0, passes = 0, fails = 0;
    logic [15:0] exp_q [$];
    logic [7:0] bytes [$];
    logic stalled_block;
    int vc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Every loader write must match the next accepted byte, in order, at its stream index.
    always @(negedge clock) begin
        if (!reset) begin
            if (!cpu_req && ram_wren1) begin
                logic [15:0] e;
                e = exp_q.size() > 0 ? exp_q.pop_front() : 16'hxxxx;
                check("ram_write", {ram_address1, ram_data1}, e);
            end
            if (cpu_req && !cpu_wren) check("cpu_exclusive", ram_wren1, 0);
        end
    end

    task automatic run_load(input int stall_at, input int stall_len);
        int cyc = 0;
        int i = 0;
        logic acc;
        stalled_block = 1'b0;
        dl_active = 1'b1;
        tick;
        while (i < bytes.size() && cyc < 300) begin
            cpu_req = cyc >= stall_at && cyc < stall_at + stall_len;
            dl_valid = 1'b1;
            dl_data = bytes[i];
            @(negedge clock);
            acc = dl_ready1;
            if (cpu_req && !acc) stalled_block = 1'b1;
            tick;
            if (acc) begin
                exp_q.push_back({8'(i), bytes[i]});
                i++;
            end
            cyc++;
        end
        check("stream_accepted", i, bytes.size());
        dl_valid = 1'b0;
        cpu_req = 1'b0;
        dl_active = 1'b0;
        tick;
    endtask

    task automatic wait_done(output int vcyc);
        vcyc = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clock);
            if (dut1.state == S_VERIFY) vcyc++;
            if (done1 && done2) break;
        end
        check("done_reached", {done1, done2}, 2'b11);
    endtask

    initial begin
        reset = 1'b1; dl_active = 1'b0; dl_valid = 1'b0; dl_data = '0;
        cpu_req = 1'b0; cpu_wren = 1'b0; cpu_address = '0; cpu_data = '0;
        tick;
        tick;
        @(negedge clock);
        check("rst_dl_ready", dl_ready1, 0);
        check("rst_busy", busy1, 0);
        check("rst_done", done1, 0);
        check("rst_error", error1, 0);
        check("rst_byte_count", byte_count1, 0);
        check("rst_checksum", checksum1, 0);
        check("rst_ram_wren", ram_wren1, 0);
        reset = 1'b0;
        tick;

        bytes = '{8'h10, 8'h20, 8'h30, 8'h40};
        run_load(1000, 0);
        wait_done(vc);
        check("basic_verify_cycles", vc, 5);
        check("basic_byte_count", byte_count1, 4);
        check("basic_checksum", checksum1, 8'hA0);
        check("basic_error", error1, 0);
        check("basic_ram", {mem1[3], mem1[2], mem1[1], mem1[0]}, 32'h40302010);
        check("basic_queue_empty", exp_q.size(), 0);

        run_load(1, 5);
        check("stall_ready_drop", stalled_block, 1);
        wait_done(vc);
        check("stall_verify_cycles", vc, 5);
        check("stall_byte_count", byte_count1, 4);
        check("stall_checksum", checksum1, 8'hA0);
        check("stall_error", error1, 0);
        check("stall_ram", {mem1[3], mem1[2], mem1[1], mem1[0]}, 32'h40302010);
        check("stall_queue_empty", exp_q.size(), 0);

        bytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        run_load(1000, 0);
        wait_done(vc);
        check("ovf_byte_count", byte_count2, 4);
        check("ovf_checksum", checksum2, 8'h0A);
        check("ovf_error", error2, 1);
        check("ovf_ram", {mem2[3], mem2[2], mem2[1], mem2[0]}, 32'h04030201);
        check("wide_byte_count", byte_count1, 6);
        check("wide_checksum", checksum1, 8'h15);
        check("wide_error", error1, 0);

        dl_active = 1'b1;
        tick;
        dl_active = 1'b0;
        tick;
        wait_done(vc);
        check("zero_byte_count", byte_count1, 0);
        check("zero_checksum", checksum1, 0);
        check("zero_error", error1, 0);
        check("zero_verify_cycles", vc, 0);
        check("zero_byte_count_small", byte_count2, 0);

        bytes = '{8'h10, 8'h20, 8'h30, 8'h40};
        run_load(1000, 0);
        for (int k = 0; k < 50; k++) begin
            @(negedge clock);
            if (dut1.state == S_VERIFY) break;
        end
        tick;
        cpu_req = 1'b1; cpu_wren = 1'b1; cpu_address = 8'd1; cpu_data = 8'h99;
        tick;
        cpu_req = 1'b0; cpu_wren = 1'b0;
        wait_done(vc);
        check("clobber_error", error1, 1);
        check("clobber_checksum", checksum1, 8'hA0);
        check("clobber_ram", mem1[1], 8'h99);

        dl_active = 1'b1;
        tick;
        dl_valid = 1'b1; dl_data = 8'h55;
        tick;
        exp_q.push_back({8'd0, 8'h55});
        dl_data = 8'h66;
        tick;
        cpu_req = 1'b1; dl_data = 8'h77;
        tick;
        check("pre_reset_byte_count", byte_count1, 1);
        reset = 1'b1; dl_active = 1'b0; dl_valid = 1'b0;
        tick;
        reset = 1'b0; cpu_req = 1'b0;
        @(negedge clock);
        check("mid_rst_busy", busy1, 0);
        check("mid_rst_done", done1, 0);
        check("mid_rst_error", error1, 0);
        check("mid_rst_byte_count", byte_count1, 0);
        check("mid_rst_checksum", checksum1, 0);
        check("mid_rst_dl_ready", dl_ready1, 0);
        for (int k = 0; k < 4; k++) begin
            check("mid_rst_no_write", ram_wren1, 0);
            @(negedge clock);
        end
        check("final_queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/spram_loader.md
# spram_loader

Streams a download image (HPS/ioctl byte stream) into a single-port RAM, sharing the RAM port with the CPU, which always has priority. After loading, it reads the image back to verify it, then reports byte count, an 8-bit additive checksum and an error flag. It sits directly upstream of the generic single-port RAM and drives that RAM's address, data and wren inputs. It consumes the RAM's registered q output, which is valid one clock after the address is presented.

## Interface
Parameters:
- address_width, 8, RAM address width; capacity is 2**address_width bytes.
- data_width, 8, RAM and stream data width.

Ports:
- clock  in  1  single clock for all logic.
- reset  in  1  synchronous, active-high.
- dl_active  in  1  download window; the rising edge starts a load, the falling edge ends it.
- dl_valid  in  1  stream byte valid.
- dl_data  in  data_width  stream byte.
- dl_ready  out  1  loader accepts dl_data this cycle.
- cpu_req  in  1  CPU owns the RAM port this cycle.
- cpu_address  in  address_width  CPU address.
- cpu_data  in  data_width  CPU write data.
- cpu_wren  in  1  CPU write enable.
- ram_address  out  address_width  to the RAM.
- ram_data  out  data_width  to the RAM.
- ram_wren  out  1  to the RAM.
- ram_q  in  data_width  RAM read data, one cycle after the address.
- busy  out  1  state is LOAD, DRAIN or VERIFY.
- done  out  1  state is DONE.
- error  out  1  overflow or verify mismatch; sticky until the next load or reset.
- byte_count  out  address_width+1  bytes written to RAM.
- checksum  out  data_width  mod-2**data_width sum of the bytes written.

## Operation
- RAM port mux (combinational):
  - cpu_req=1: ram_address/ram_data/ram_wren = cpu_address/cpu_data/cpu_wren.
  - cpu_req=0: the loader drives the port; ram_wren=0 when the loader is idle.
- States: IDLE, LOAD, DRAIN, VERIFY, DONE.
- IDLE/DONE -> LOAD on a dl_active rising edge. LOAD clears the write pointer, byte_count, checksum, error, the overflow flag and the FIFO.
- LOAD:
  - dl_ready = FIFO not full.
  - A byte is accepted on dl_valid && dl_ready.
  - Once 2**address_width bytes have been accepted, further bytes are still acknowledged (dl_ready stays high) but discarded, and the overflow flag is set.
  - On any cycle with cpu_req=0 and the FIFO not empty, the loader pops one byte, writes it at the write pointer, adds it to checksum, and increments the pointer and byte_count.
- LOAD -> DRAIN on dl_active falling. In DRAIN, dl_ready=0 and the FIFO keeps emptying.
- DRAIN -> VERIFY when the FIFO is empty and byte_count>0; DRAIN -> DONE when byte_count=0 (checksum 0, error = overflow).
- VERIFY:
  - Issues reads of addresses 0..byte_count-1, one per cycle with cpu_req=0, and sums ram_q into a verify sum.
  - A read issued while cpu_req=1 is not issued and is retried. The sample of ram_q is taken only for reads actually issued (tracked by a 1-bit read-pending register).
  - VERIFY -> DONE once the last sample is taken. error = overflow OR (verify sum != checksum).
- A dl_active rising edge during LOAD/DRAIN/VERIFY is ignored. A dl_active rise in DONE restarts the load.
- Width rules: byte_count saturates at 2**address_width; the write pointer does not wrap; checksum wraps modulo 2**data_width.

## Timing
- Reset values: state IDLE, dl_ready=0, busy=0, done=0, error=0, byte_count=0, checksum=0, FIFO empty, loader ram_wren=0.
- Reset mid-operation abandons the load immediately; no further loader writes occur after the reset cycle.
- Byte accepted in cycle N -> RAM write no earlier than N+1 (FIFO registered), N+1 exactly if cpu_req=0 and the FIFO was empty.
- FIFO depth is 2. With cpu_req=0 throughout, dl_ready stays high and the load runs at one byte per cycle.
- A CPU stall of k cycles loses no bytes: dl_ready drops once 2 bytes are queued.
- VERIFY for n bytes with no CPU contention: DONE in n+1 cycles after entering VERIFY. Each CPU-held cycle adds one cycle.
- dl_active edges are detected with a registered previous value, so the state changes one cycle after the edge.

## Structure
- spram_loader_pkg: state encoding constants (IDLE..DONE) and the FIFO depth constant (2).
- One sub-module, loader_skid_fifo: 2-entry FIFO with push/pop/full/empty and synchronous reset/clear.
- The RAM itself is not instantiated here; the parent instantiates it beside this block.

## Test plan
- Load 4 bytes 0x10,0x20,0x30,0x40 with cpu_req=0 -> RAM holds them at 0..3, byte_count=4, checksum=0xA0, DONE, error=0, verify completes 5 cycles after entering VERIFY.
- Same stream with cpu_req=1 for 5 cycles mid-load -> dl_ready deasserts after 2 queued bytes, no CPU cycle sees loader writes, final result identical.
- address_width=2, stream 6 bytes -> 4 written, byte_count=4, error=1, DONE.
- Zero-length download (dl_active pulse, no dl_valid) -> DONE, byte_count=0, checksum=0, error=0, no RAM writes.
- Force a CPU write to address 1 during VERIFY before it is read -> verify sum mismatch, error=1.
- Assert reset in the middle of LOAD -> next cycle state IDLE, all outputs 0, no further loader ram_wren.
